// File: rtl/pipeline_ctrl.sv
// Hazard, stall, flush and redirect control for the five-stage pipeline.
// Request arbitration is combinational; only the wait states are registered.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_use_hazard,
  input  logic                  branch_mispredict,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  div_start,
  input  logic                  div_done,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  exception_req,
  input  logic [ADDR_WIDTH-1:0] exception_vector,
  input  logic                  eret_req,
  input  logic [ADDR_WIDTH-1:0] epc,
  output logic [4:0]            stall,
  output logic [4:0]            flush,
  output logic                  global_flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  div_abort,
  output logic                  bus_error,
  output logic [1:0]            state,
  output logic [31:0]           stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  localparam int TW =
    ($clog2(MEM_TIMEOUT) > 8) ? $clog2(MEM_TIMEOUT) : 8;
  // The RUN entry cycle counts as the first cycle of the access, so the
  // counter hits MEM_TIMEOUT-1 as it increments past MEM_TIMEOUT-2.
  localparam logic [TW-1:0] TO_HIT = TW'(MEM_TIMEOUT - 2);

  localparam logic [4:0] ST_MEM = 5'b01111;
  localparam logic [4:0] FL_MEM = 5'b10000;
  localparam logic [4:0] ST_DIV = 5'b00111;
  localparam logic [4:0] FL_DIV = 5'b01000;
  localparam logic [4:0] ST_LU  = 5'b00011;
  localparam logic [4:0] FL_LU  = 5'b00100;
  localparam logic [4:0] FL_BR  = 5'b00110;

  state_t          cur;
  state_t          nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            mem_stall;
  logic            tmo_hit;

  assign mem_stall = mem_req & ~mem_ack;
  assign tmo_hit   = (tmo_cnt == TO_HIT);
  assign state     = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= RUN;
    else        cur <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               tmo_cnt <= '0;
    else if (cur == MEM_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
    else                      tmo_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_cycles <= '0;
    else if (|stall) stall_cycles <= stall_cycles + 32'd1;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      RUN: begin
        priority case (1'b1)
          exception_req:     nxt = RUN;
          eret_req:          nxt = RUN;
          mem_stall:         nxt = MEM_WAIT;
          branch_mispredict: nxt = RUN;
          div_start:         nxt = div_done ? RUN : DIV_WAIT;
          default:           nxt = RUN;
        endcase
      end
      MEM_WAIT: begin
        if (mem_ack || tmo_hit) nxt = RUN;
      end
      DIV_WAIT: begin
        if (exception_req || eret_req || div_done) nxt = RUN;
      end
      default: nxt = RUN;
    endcase
  end

  always_comb begin
    stall          = '0;
    flush          = '0;
    global_flush   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    div_abort      = 1'b0;
    bus_error      = 1'b0;
    unique case (cur)
      RUN: begin
        priority case (1'b1)
          exception_req: begin
            global_flush   = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = exception_vector;
          end
          eret_req: begin
            global_flush   = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = epc;
          end
          mem_stall: begin
            stall = ST_MEM;
            flush = FL_MEM;
          end
          branch_mispredict: begin
            flush          = FL_BR;
            redirect_valid = 1'b1;
            redirect_pc    = branch_target;
          end
          div_start: begin
            if (!div_done) begin
              stall = ST_DIV;
              flush = FL_DIV;
            end
          end
          load_use_hazard: begin
            stall = ST_LU;
            flush = FL_LU;
          end
          default: ;
        endcase
      end
      MEM_WAIT: begin
        if (mem_ack) begin
        end else if (tmo_hit) begin
          bus_error = 1'b1;
        end else begin
          stall = ST_MEM;
          flush = FL_MEM;
        end
      end
      DIV_WAIT: begin
        if (exception_req || eret_req) begin
          global_flush   = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = exception_req ? exception_vector : epc;
          div_abort      = 1'b1;
        end else if (!div_done) begin
          stall = ST_DIV;
          flush = FL_DIV;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; expected outputs queued per step
// and compared at the following falling edge.
module tb_pipeline_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_use_hazard;
  logic          branch_mispredict;
  logic [AW-1:0] branch_target;
  logic          div_start;
  logic          div_done;
  logic          mem_req;
  logic          mem_ack;
  logic          exception_req;
  logic [AW-1:0] exception_vector;
  logic          eret_req;
  logic [AW-1:0] epc;
  logic [4:0]    stall;
  logic [4:0]    flush;
  logic          global_flush;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          div_abort;
  logic          bus_error;
  logic [1:0]    state;
  logic [31:0]   stall_cycles;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_use_hazard  (load_use_hazard),
    .branch_mispredict(branch_mispredict),
    .branch_target    (branch_target),
    .div_start        (div_start),
    .div_done         (div_done),
    .mem_req          (mem_req),
    .mem_ack          (mem_ack),
    .exception_req    (exception_req),
    .exception_vector (exception_vector),
    .eret_req         (eret_req),
    .epc              (epc),
    .stall            (stall),
    .flush            (flush),
    .global_flush     (global_flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .div_abort        (div_abort),
    .bus_error        (bus_error),
    .state            (state),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    st;
    logic [4:0]    fl;
    logic          gf;
    logic          rv;
    logic [AW-1:0] pc;
    logic          ab;
    logic          be;
    logic [1:0]    fsm;
    string         tag;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sc_model = 0;

  localparam logic [AW-1:0] VEC = 32'h8000_0180;
  localparam logic [AW-1:0] EPC = 32'h0000_1234;
  localparam logic [AW-1:0] BRT = 32'h0040_0020;

  function automatic exp_t mk(string tag, logic [4:0] st, logic [4:0] fl,
                              logic gf, logic rv, logic [AW-1:0] pc,
                              logic ab, logic be, logic [1:0] fsm);
    exp_t e;
    e.tag = tag; e.st = st; e.fl = fl; e.gf = gf; e.rv = rv;
    e.pc = pc; e.ab = ab; e.be = be; e.fsm = fsm;
    return e;
  endfunction

  task automatic chk(string tag, string fld, logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "stall", 32'(stall), 32'(e.st));
    chk(e.tag, "flush", 32'(flush), 32'(e.fl));
    chk(e.tag, "gflush", 32'(global_flush), 32'(e.gf));
    chk(e.tag, "rvalid", 32'(redirect_valid), 32'(e.rv));
    chk(e.tag, "rpc", redirect_pc, e.pc);
    chk(e.tag, "abort", 32'(div_abort), 32'(e.ab));
    chk(e.tag, "berr", 32'(bus_error), 32'(e.be));
    chk(e.tag, "state", 32'(state), 32'(e.fsm));
    chk(e.tag, "scnt", stall_cycles, sc_model);
    if (rst_n && e.st != 5'd0) sc_model++;
  endtask

  task automatic step(exp_t e);
    sb.push_back(e);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    load_use_hazard   = 1'b0;
    branch_mispredict = 1'b0;
    branch_target     = '0;
    div_start         = 1'b0;
    div_done          = 1'b0;
    mem_req           = 1'b0;
    mem_ack           = 1'b0;
    exception_req     = 1'b0;
    exception_vector  = VEC;
    eret_req          = 1'b0;
    epc               = EPC;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    step(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0));

    mem_req = 1'b1;
    step(mk("mem_c1", 5'b01111, 5'b10000, 0, 0, 0, 0, 0, 0));
    step(mk("mem_c2", 5'b01111, 5'b10000, 0, 0, 0, 0, 0, 1));
    mem_req = 1'b0;
    step(mk("mem_c3", 5'b01111, 5'b10000, 0, 0, 0, 0, 0, 1));
    mem_ack = 1'b1;
    step(mk("mem_ack", 0, 0, 0, 0, 0, 0, 0, 1));
    clr();
    step(mk("mem_done", 0, 0, 0, 0, 0, 0, 0, 0));

    mem_req = 1'b1; mem_ack = 1'b1;
    step(mk("mem_fast", 0, 0, 0, 0, 0, 0, 0, 0));
    clr();

    load_use_hazard = 1'b1;
    step(mk("lu", 5'b00011, 5'b00100, 0, 0, 0, 0, 0, 0));
    clr();
    step(mk("lu_once", 0, 0, 0, 0, 0, 0, 0, 0));

    branch_mispredict = 1'b1; load_use_hazard = 1'b1;
    div_start = 1'b1; branch_target = BRT;
    step(mk("br_lu", 0, 5'b00110, 0, 1, BRT, 0, 0, 0));
    clr();

    exception_req = 1'b1; eret_req = 1'b1;
    step(mk("exc_eret", 0, 0, 1, 1, VEC, 0, 0, 0));
    clr();
    eret_req = 1'b1; mem_req = 1'b1;
    step(mk("eret", 0, 0, 1, 1, EPC, 0, 0, 0));
    clr();

    div_start = 1'b1;
    step(mk("div_go", 5'b00111, 5'b01000, 0, 0, 0, 0, 0, 0));
    clr();
    step(mk("div_wait", 5'b00111, 5'b01000, 0, 0, 0, 0, 0, 2));
    exception_req = 1'b1;
    step(mk("div_exc", 0, 0, 1, 1, VEC, 1, 0, 2));
    clr();
    step(mk("div_exc_run", 0, 0, 0, 0, 0, 0, 0, 0));

    div_start = 1'b1; div_done = 1'b1;
    step(mk("div_fast", 0, 0, 0, 0, 0, 0, 0, 0));
    clr();
    step(mk("div_fast_run", 0, 0, 0, 0, 0, 0, 0, 0));

    div_start = 1'b1;
    step(mk("div_go2", 5'b00111, 5'b01000, 0, 0, 0, 0, 0, 0));
    clr();
    branch_mispredict = 1'b1; load_use_hazard = 1'b1;
    branch_target = BRT;
    step(mk("div_ign", 5'b00111, 5'b01000, 0, 0, 0, 0, 0, 2));
    clr();
    div_done = 1'b1;
    step(mk("div_done", 0, 0, 0, 0, 0, 0, 0, 2));
    clr();
    step(mk("div_ret", 0, 0, 0, 0, 0, 0, 0, 0));

    mem_req = 1'b1; branch_mispredict = 1'b1; branch_target = BRT;
    step(mk("mem_over_br", 5'b01111, 5'b10000, 0, 0, 0, 0, 0, 0));
    clr();
    exception_req = 1'b1; eret_req = 1'b1;
    step(mk("mw_exc_ign", 5'b01111, 5'b10000, 0, 0, 0, 0, 0, 1));
    clr();
    mem_ack = 1'b1;
    step(mk("mw_ack", 0, 0, 0, 0, 0, 0, 0, 1));
    clr();

    mem_req = 1'b1;
    step(mk("to_c1", 5'b01111, 5'b10000, 0, 0, 0, 0, 0, 0));
    step(mk("to_c2", 5'b01111, 5'b10000, 0, 0, 0, 0, 0, 1));
    step(mk("to_c3", 5'b01111, 5'b10000, 0, 0, 0, 0, 0, 1));
    step(mk("to_berr", 0, 0, 0, 0, 0, 0, 1, 1));
    mem_req = 1'b0;
    step(mk("to_run", 0, 0, 0, 0, 0, 0, 0, 0));

    div_start = 1'b1;
    step(mk("rst_div_go", 5'b00111, 5'b01000, 0, 0, 0, 0, 0, 0));
    clr();
    step(mk("rst_div_w", 5'b00111, 5'b01000, 0, 0, 0, 0, 0, 2));
    #2;
    rst_n = 1'b0;
    #1;
    sc_model = 0;
    sb.push_back(mk("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0));
    compare_head();
    step(mk("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step(mk("rst_rel", 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the MEM_WAIT cycle limit before bus error.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, the redirect PC width.
REQ-003 SHALL use one clock and an asynchronous active-low reset; port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have the following inputs:
- load_use_hazard, 1: decode instruction needs a load result still in exec.
- branch_mispredict, 1: exec resolved a mispredicted branch.
- branch_target, ADDR_WIDTH: correct PC for branch_mispredict.
- div_start, 1: exec begins a multi-cycle divide.
- div_done, 1: divider result valid.
- mem_req, 1: mem stage issues a data access.
- mem_ack, 1: data memory completes the access.
- exception_req, 1: mem stage raises an exception.
- exception_vector, ADDR_WIDTH: handler address.
- eret_req, 1: mem stage executes ERET.
- epc, ADDR_WIDTH: ERET return address.
REQ-006 SHALL have the following outputs:
- stall, 5: per-boundary stall; bit 0 PC, 1 fetch2dec, 2 dec2exec, 3 exec2mem, 4 mem2wb.
- flush, 5: per-boundary bubble insert, same bit map.
- global_flush, 1: flush all pipeline registers.
- redirect_valid, 1: load redirect_pc into PC.
- redirect_pc, ADDR_WIDTH: fetch redirect target.
- div_abort, 1: cancel the divider.
- bus_error, 1: one-cycle pulse on memory timeout.
- state, 2: current FSM state.
- stall_cycles, 32: count of cycles with any stall bit set.

Function
REQ-007 SHALL implement FSM states RUN=0, MEM_WAIT=1, DIV_WAIT=2; state is registered, and stall, flush, global_flush, redirect_* and div_abort are combinational from state and inputs, giving zero-cycle latency.
REQ-008 In RUN, SHALL resolve requests with priority exception_req > eret_req > mem stall > branch_mispredict > div_start > load_use_hazard, and only the highest active request takes effect.
REQ-009 Exception in RUN or DIV_WAIT SHALL drive:
- global_flush=1, redirect_valid=1, redirect_pc=exception_vector, stall=0.
- div_abort=1 when in DIV_WAIT.
- next state RUN.
REQ-010 ERET with no exception SHALL behave as REQ-009 except redirect_pc=epc.
REQ-011 Mem stall in RUN (mem_req=1, mem_ack=0) SHALL drive stall=5'b01111 and flush=5'b10000, clear the timeout counter, and go to MEM_WAIT.
REQ-012 mem_req=1 with mem_ack=1 in the same RUN cycle SHALL cause no stall.
REQ-013 In MEM_WAIT, SHALL drive stall=5'b01111 and flush=5'b10000 while mem_ack=0, and increment the 8-bit-minimum timeout counter each cycle.
REQ-014 mem_ack=1 in MEM_WAIT SHALL release the stall in that same cycle (stall=0, flush=0) and return to RUN.
REQ-015 When the timeout counter reaches MEM_TIMEOUT-1 with no ack, SHALL pulse bus_error for one cycle, release the stall that cycle, and return to RUN.
REQ-016 exception_req and eret_req SHALL be ignored in MEM_WAIT because an in-flight bus access is not abortable.
REQ-017 Branch mispredict in RUN SHALL drive:
- flush=5'b00110, redirect_valid=1, redirect_pc=branch_target, stall=0.
- A simultaneous load_use_hazard or div_start is discarded as wrong-path.
REQ-018 div_start in RUN SHALL drive stall=5'b00111 and flush=5'b01000, then go to DIV_WAIT; if div_done=1 in the same cycle, SHALL drive no stall and stay in RUN.
REQ-019 In DIV_WAIT, SHALL drive stall=5'b00111 and flush=5'b01000 until div_done=1; in the div_done cycle SHALL drive stall=0 and return to RUN; load_use_hazard and branch_mispredict are ignored.
REQ-020 Load-use in RUN SHALL drive stall=5'b00011 and flush=5'b00100 for that cycle only, with no state change.
REQ-021 With no request active, SHALL drive stall=0, flush=0, global_flush=0, redirect_valid=0, redirect_pc=0.
REQ-022 stall_cycles SHALL increment each cycle where stall!=0 and wrap from 2^32-1 to 0.

Reset
REQ-023 When rst_n=0, SHALL asynchronously force state=RUN, the timeout counter to 0, stall_cycles=0 and bus_error=0, with all combinational outputs at their REQ-021 idle values.
REQ-024 Reset asserted mid-MEM_WAIT or mid-DIV_WAIT SHALL abandon the wait, with no bus_error or div_abort produced.

Verification
REQ-025 The bench SHALL cover mem_req=1 with mem_ack low for 3 cycles then high: stall=01111 and flush=10000 for 3 cycles, 0 on the ack cycle, state 0->1->1->1->0, stall_cycles=3.
REQ-026 The bench SHALL cover div_start, then exception_req 2 cycles later: global_flush=1, div_abort=1, redirect_pc=exception_vector, state back to 0 next cycle.
REQ-027 The bench SHALL cover branch_mispredict=1, load_use_hazard=1 and branch_target=0x00400020 together: flush=00110, stall=0, redirect_pc=0x00400020.
REQ-028 The bench SHALL cover MEM_TIMEOUT=4 with mem_req held and no ack: a bus_error pulse on the 4th stalled cycle and state RUN next cycle.
REQ-029 The bench SHALL cover exception_req=1 and eret_req=1 together in RUN: redirect_pc=exception_vector and global_flush=1.
REQ-030 The bench SHALL cover rst_n dropped during DIV_WAIT: state=0, stall=0 and stall_cycles=0 immediately, with no div_abort.
